// File: rtl/demux12_2bits_buffered.sv
// rtl/demux12_2bits_buffered.sv - 1:2 demux for 2-bit words with an independent FIFO per output lane
module demux12_2bits_buffered #(
   parameter int DATA_W     = 2,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = 8
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [DATA_W-1:0] data_in,
   input  logic              sel_in,
   input  logic              valid_in,
   output logic              ready_in,
   output logic [DATA_W-1:0] data_out0,
   output logic              valid_out0,
   input  logic              ready_out0,
   output logic [DATA_W-1:0] data_out1,
   output logic              valid_out1,
   input  logic              ready_out1,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [1:0]             full;
   logic [1:0]             valid;
   logic [1:0]             take;
   logic [1:0]             lane_sel;
   logic [1:0][DATA_W-1:0] head;
   logic [1:0][CNT_W-1:0]  cnt;
   logic                   accept;

   // Full flags come from registered occupancy, so a pop this cycle never opens space until the next.
   assign lane_sel = {sel_in, ~sel_in};
   assign ready_in = reset_L & ~full[sel_in];
   assign accept   = valid_in & ready_in;
   assign take     = {ready_out1, ready_out0};

   genvar k;
   generate
      for (k = 0; k < 2; k++) begin : g_lane
         logic [DATA_W-1:0] mem [FIFO_DEPTH];
         logic [PTR_W-1:0]  wr_ptr;
         logic [PTR_W-1:0]  rd_ptr;
         logic [PTR_W:0]    occ;
         logic [CNT_W-1:0]  words;
         logic              push;
         logic              pop;

         assign push     = accept & lane_sel[k];
         assign pop      = valid[k] & take[k];
         assign valid[k] = (occ != '0);
         assign full[k]  = (occ == (PTR_W+1)'(FIFO_DEPTH));
         assign head[k]  = valid[k] ? mem[rd_ptr] : '0;
         assign cnt[k]   = words;

         always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
               for (int i = 0; i < FIFO_DEPTH; i++) begin
                  mem[i] <= '0;
               end
               wr_ptr <= '0;
               rd_ptr <= '0;
               occ    <= '0;
               words  <= '0;
            end else begin
               if (push) begin
                  mem[wr_ptr] <= data_in;
                  wr_ptr      <= wr_ptr + 1'b1;
                  words       <= words + 1'b1;
               end
               if (pop) begin
                  rd_ptr <= rd_ptr + 1'b1;
               end
               if (push && !pop) begin
                  occ <= occ + 1'b1;
               end else if (pop && !push) begin
                  occ <= occ - 1'b1;
               end
            end
         end
      end
   endgenerate

   assign data_out0  = head[0];
   assign data_out1  = head[1];
   assign valid_out0 = valid[0];
   assign valid_out1 = valid[1];
   assign cnt0       = cnt[0];
   assign cnt1       = cnt[1];
endmodule

// File: tb/tb_demux12_2bits_buffered.sv
// tb/tb_demux12_2bits_buffered.sv - scoreboard bench for demux12_2bits_buffered
module tb_demux12_2bits_buffered;
   logic       clk;
   logic       reset_L;
   logic [1:0] data_in;
   logic       sel_in;
   logic       valid_in;
   logic       ready_in;
   logic [1:0] data_out0;
   logic       valid_out0;
   logic       ready_out0;
   logic [1:0] data_out1;
   logic       valid_out1;
   logic       ready_out1;
   logic [7:0] cnt0;
   logic [7:0] cnt1;

   int checks   = 0;
   int failures = 0;
   logic [1:0] exp0 [$];
   logic [1:0] exp1 [$];

   demux12_2bits_buffered #(.DATA_W(2), .FIFO_DEPTH(2), .CNT_W(8)) dut (
      .clk        (clk),
      .reset_L    (reset_L),
      .data_in    (data_in),
      .sel_in     (sel_in),
      .valid_in   (valid_in),
      .ready_in   (ready_in),
      .data_out0  (data_out0),
      .valid_out0 (valid_out0),
      .ready_out0 (ready_out0),
      .data_out1  (data_out1),
      .valid_out1 (valid_out1),
      .ready_out1 (ready_out1),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every pop the DUT performs is compared against the scoreboard head for that lane.
   always @(negedge clk) begin
      logic [1:0] e;
      if (reset_L) begin
         if (valid_out0 && ready_out0) begin
            if (exp0.size() == 0) check("lane0_unexpected_pop", {30'd0, data_out0}, 32'hFFFF_FFFF);
            else begin
               e = exp0.pop_front();
               check("lane0_data", {30'd0, data_out0}, {30'd0, e});
            end
         end
         if (valid_out1 && ready_out1) begin
            if (exp1.size() == 0) check("lane1_unexpected_pop", {30'd0, data_out1}, 32'hFFFF_FFFF);
            else begin
               e = exp1.pop_front();
               check("lane1_data", {30'd0, data_out1}, {30'd0, e});
            end
         end
         if (!valid_out0) check("lane0_idle_zero", {30'd0, data_out0}, 32'd0);
         if (!valid_out1) check("lane1_idle_zero", {30'd0, data_out1}, 32'd0);
      end
   end

   // Present a word, hold it until ready_in, record the expected value, let the edge accept it.
   task automatic send(input logic s, input logic [1:0] d);
      int n;
      valid_in = 1'b1;
      sel_in   = s;
      data_in  = d;
      n = 0;
      @(negedge clk);
      while (!ready_in && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready_in) check("send_timeout", 32'd0, 32'd1);
      else if (s) exp1.push_back(d);
      else exp0.push_back(d);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp0.size() != 0 || exp1.size() != 0) && n < 40) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_empty", exp0.size() + exp1.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_L    = 1'b0;
      data_in    = 2'b00;
      sel_in     = 1'b0;
      valid_in   = 1'b0;
      ready_out0 = 1'b0;
      ready_out1 = 1'b0;
      #2;
      check("rst_valid_out0", {31'd0, valid_out0}, 32'd0);
      check("rst_valid_out1", {31'd0, valid_out1}, 32'd0);
      check("rst_ready_in", {31'd0, ready_in}, 32'd0);
      check("rst_cnt0", {24'd0, cnt0}, 32'd0);
      check("rst_cnt1", {24'd0, cnt1}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_L = 1'b1;
      @(posedge clk);
      #1;

      // Routing with both consumers ready.
      ready_out0 = 1'b1;
      ready_out1 = 1'b1;
      send(1'b0, 2'b01);
      check("route_latency_valid0", {31'd0, valid_out0}, 32'd1);
      check("route_latency_data0", {30'd0, data_out0}, 32'd1);
      send(1'b1, 2'b10);
      send(1'b0, 2'b11);
      drain();
      check("route_cnt0", {24'd0, cnt0}, 32'd2);
      check("route_cnt1", {24'd0, cnt1}, 32'd1);

      // Backpressure: lane 0 fills, lane 1 still accepts in the same cycle.
      ready_out0 = 1'b0;
      send(1'b0, 2'b01);
      send(1'b0, 2'b10);
      valid_in = 1'b1;
      sel_in   = 1'b0;
      data_in  = 2'b11;
      @(negedge clk);
      check("full_lane0_ready", {31'd0, ready_in}, 32'd0);
      #1;
      sel_in  = 1'b1;
      data_in = 2'b10;
      #1;
      check("other_lane_ready", {31'd0, ready_in}, 32'd1);
      exp1.push_back(2'b10);
      @(posedge clk);
      #1;

      // Full lane with a pop in the same cycle: push refused now, accepted next cycle.
      sel_in     = 1'b0;
      data_in    = 2'b11;
      ready_out0 = 1'b1;
      @(negedge clk);
      check("full_pop_ready", {31'd0, ready_in}, 32'd0);
      send(1'b0, 2'b11);
      drain();
      check("full_cnt0", {24'd0, cnt0}, 32'd5);

      // Push and pop together on a partially filled lane 1.
      ready_out1 = 1'b0;
      send(1'b1, 2'b01);
      ready_out1 = 1'b1;
      send(1'b1, 2'b11);
      ready_out1 = 1'b0;
      check("pp_valid1", {31'd0, valid_out1}, 32'd1);
      check("pp_data1", {30'd0, data_out1}, 32'd3);
      send(1'b1, 2'b10);
      valid_in = 1'b1;
      sel_in   = 1'b1;
      #1;
      check("pp_lane1_full", {31'd0, ready_in}, 32'd0);
      valid_in   = 1'b0;
      ready_out1 = 1'b1;
      drain();
      check("pp_cnt1", {24'd0, cnt1}, 32'd5);

      // Asynchronous reset with two words sitting in lane 0.
      ready_out0 = 1'b0;
      send(1'b0, 2'b01);
      send(1'b0, 2'b10);
      check("pre_reset_valid0", {31'd0, valid_out0}, 32'd1);
      reset_L = 1'b0;
      #1;
      exp0.delete();
      exp1.delete();
      check("mid_rst_valid0", {31'd0, valid_out0}, 32'd0);
      check("mid_rst_data0", {30'd0, data_out0}, 32'd0);
      check("mid_rst_cnt0", {24'd0, cnt0}, 32'd0);
      check("mid_rst_ready_in", {31'd0, ready_in}, 32'd0);
      @(negedge clk);
      reset_L    = 1'b1;
      ready_out0 = 1'b1;
      @(posedge clk);
      #1;
      send(1'b0, 2'b11);
      check("post_rst_valid0", {31'd0, valid_out0}, 32'd1);
      check("post_rst_data0", {30'd0, data_out0}, 32'd3);
      drain();

      // 256 accepts into lane 1 wrap its counter back to zero.
      for (int i = 0; i < 256; i++) begin
         send(1'b1, 2'(i));
      end
      drain();
      check("wrap_cnt1", {24'd0, cnt1}, 32'd0);
      check("wrap_cnt0", {24'd0, cnt0}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/demux12_2bits_buffered.md
Name: demux12_2bits_buffered

Overview:
- 1:2 demultiplexer for 2-bit data; the receive-side counterpart of the 2:1 2-bit multiplexer path.
- Accepts one valid/ready input stream and routes each word, by a per-word selector, into one of two output lanes.
- Each lane has its own small FIFO and its own valid/ready handshake, so a stalled lane does not corrupt or reorder the other lane.
- Sits after the registered mux output stage and feeds two independent 2-bit consumers.

Parameters:
- DATA_W, 2, width of each data word.
- FIFO_DEPTH, 2, entries per lane. Must be a power of two and at least 2.
- CNT_W, 8, width of the per-lane routed-word counters.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- reset_L  input  1  reset, asynchronous and active-low.
- data_in  input  DATA_W  incoming word.
- sel_in  input  1  destination lane for data_in: 0 = lane 0, 1 = lane 1.
- valid_in  input  1  data_in/sel_in are valid this cycle.
- ready_in  output  1  block can accept the word on the lane named by sel_in.
- data_out0  output  DATA_W  head word of lane 0.
- valid_out0  output  1  lane 0 FIFO non-empty.
- ready_out0  input  1  lane 0 consumer takes the head this cycle.
- data_out1  output  DATA_W  head word of lane 1.
- valid_out1  output  1  lane 1 FIFO non-empty.
- ready_out1  input  1  lane 1 consumer takes the head this cycle.
- cnt0  output  CNT_W  words accepted into lane 0 since reset.
- cnt1  output  CNT_W  words accepted into lane 1 since reset.

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-low.
- Reset (reset_L=0, any time, including mid-transfer):
  - Immediately clears all FIFO storage, pointers, occupancy counts and cnt0/cnt1.
  - Outputs go to ready_in=0, valid_out0/1=0, data_out0/1=0, cnt0/1=0.
  - Contents in flight are discarded.
  - First acceptance is possible in the first posedge after reset_L rises.
- Input handshake:
  - ready_in = NOT full(lane[sel_in]) while reset_L=1. It is combinational from sel_in and the registered full flags.
  - Accept = valid_in AND ready_in. On accept, data_in is written at the tail of lane[sel_in] and that lane's count increments.
  - sel_in and data_in are don't-care when valid_in=0.
  - valid_in=1 with the target lane full: the word is not accepted. The source must hold data_in/sel_in stable until ready_in=1. The other lane is unaffected.
- Output handshake, per lane k:
  - valid_outk = (occupancy_k != 0), registered.
  - data_outk = storage[rd_ptr_k] when valid, else 0.
  - Pop = valid_outk AND ready_outk. rd_ptr_k advances by one.
  - ready_outk with valid_outk=0 has no effect.
- Latency: a word accepted at edge N is visible on valid_outk/data_outk after edge N. No same-cycle pass-through.
- Simultaneous push and pop on the same lane (lane not full): occupancy unchanged, both pointers advance.
- Full lane: ready_in is low for that lane even if a pop occurs in the same cycle. A pop frees space only for the next cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Occupancy is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- Ordering: order is preserved within each lane. There is no ordering relation between lanes.
- cntk increments by 1 on each accept into lane k and wraps modulo 2^CNT_W (255 -> 0 for CNT_W=8).
- No state machine beyond the per-lane FIFO state: EMPTY (occ=0), PARTIAL (0<occ<DEPTH), FULL (occ=DEPTH).
  - push only: occ+1.
  - pop only: occ-1.
  - push+pop: hold.

Test Plan:
- Reset check: assert reset_L=0 mid-stream with lane 0 holding 2 words -> same cycle valid_out0=0, data_out0=2'b00, cnt0=0, ready_in=0. After release, a push of 2'b11 to lane 0 appears next cycle.
- Routing: with ready_out0/1=1, send (2'b01,sel=0), (2'b10,sel=1), (2'b11,sel=0) on consecutive cycles -> lane0 outputs 01 then 11, lane1 outputs 10, each one cycle after accept. Final values cnt0=2, cnt1=1.
- Backpressure/full: ready_out0=0, push 2'b01 and 2'b10 to lane 0 -> third push to lane 0 sees ready_in=0 and is held. In the same cycle, sel_in=1 gives ready_in=1 and lane 1 accepts.
- Full with simultaneous pop: lane 0 full, ready_out0=1 and a valid push to lane 0 in the same cycle -> push refused that cycle and accepted the next. Output order 01,10,new.
- Simultaneous push/pop, partial: lane 1 holds one word, push and pop on the same cycle -> occupancy stays 1, valid_out1 stays 1, data sequence preserved.
- Counter wrap: 256 accepts into lane 1 -> cnt1 returns to 0 and cnt0 is unchanged.
